// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl
// Operand-forwarding and hazard control for the EXE stage of a 5-stage
// ARM pipeline. A shadow pipeline (EXE, MEM, WB slots) tracks the
// destination, write-back enable and load flag of in-flight instructions.
// Forwarding selects are registered so they line up with the consumer when
// it reaches EXE. The hazard flag is combinational; it freezes PC and IF/ID
// and bubbles EXE.
//
// There is no valid/ready handshake on this block: every input is sampled on
// every rising edge, and hazard is the only back-pressure signal.
//
// Select encoding for the EXE operand muxes:
//   00 = register-file value from ID, 01 = WB value, 10 = MEM value.
//   11 is never driven.
module forward_hazard_ctrl #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  forward_en,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  output logic                  hazard,
  output logic [1:0]            sel_src1,
  output logic [1:0]            sel_src2,
  output logic [REG_ADDR_W-1:0] exe_dest_o,
  output logic [REG_ADDR_W-1:0] mem_dest_o,
  output logic [REG_ADDR_W-1:0] wb_dest_o
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // EXE slot: all three fields are needed (load flag drives load-use).
  logic [REG_ADDR_W-1:0] exe_dest_q, exe_dest_d;
  logic                  exe_wb_en_q, exe_wb_en_d;
  logic                  exe_mem_r_q, exe_mem_r_d;

  // MEM slot: the load flag has no reader once the producer leaves EXE,
  // and the WB slot never participates in matching (the register file
  // handles write-through itself), so only the observable fields are kept.
  logic [REG_ADDR_W-1:0] mem_dest_q;
  logic                  mem_wb_en_q;
  logic [REG_ADDR_W-1:0] wb_dest_q;

  logic [1:0] sel_src1_q, sel_src1_d;
  logic [1:0] sel_src2_q, sel_src2_d;

  // Per-source matches against the EXE and MEM producers.
  logic m_exe1, m_exe2, m_mem1, m_mem2;

  // Match a used source against the producers in EXE and MEM.
  always_comb begin
    m_exe1 = exe_wb_en_q && (exe_dest_q == id_src1);
    m_mem1 = mem_wb_en_q && (mem_dest_q == id_src1);
    // An unused second operand can never match, whatever its field holds.
    m_exe2 = id_two_src && exe_wb_en_q && (exe_dest_q == id_src2);
    m_mem2 = id_two_src && mem_wb_en_q && (mem_dest_q == id_src2);
  end

  // Hazard: load-use only when forwarding, any in-flight producer otherwise.
  always_comb begin
    hazard = 1'b0;
    if (forward_en) begin
      hazard = exe_mem_r_q && (m_exe1 || m_exe2);
    end else begin
      hazard = m_exe1 || m_exe2 || m_mem1 || m_mem2;
    end
  end

  // Next-state: EXE slot load (or bubble) and forwarding selects.
  always_comb begin
    exe_dest_d  = id_dest;
    exe_wb_en_d = id_wb_en;
    exe_mem_r_d = id_mem_r_en;
    sel_src1_d  = SEL_REG;
    sel_src2_d  = SEL_REG;

    if (hazard || flush) begin
      exe_dest_d  = '0;
      exe_wb_en_d = 1'b0;
      exe_mem_r_d = 1'b0;
    end

    // The EXE producer is younger, so it wins over the MEM producer.
    if (!hazard && !flush && forward_en) begin
      if (m_exe1) begin
        sel_src1_d = SEL_MEM;
      end else if (m_mem1) begin
        sel_src1_d = SEL_WB;
      end

      if (m_exe2) begin
        sel_src2_d = SEL_MEM;
      end else if (m_mem2) begin
        sel_src2_d = SEL_WB;
      end
    end
  end

  // State register: slots shift every edge; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_dest_q  <= '0;
      exe_wb_en_q <= 1'b0;
      exe_mem_r_q <= 1'b0;
      mem_dest_q  <= '0;
      mem_wb_en_q <= 1'b0;
      wb_dest_q   <= '0;
      sel_src1_q  <= SEL_REG;
      sel_src2_q  <= SEL_REG;
    end else begin
      exe_dest_q  <= exe_dest_d;
      exe_wb_en_q <= exe_wb_en_d;
      exe_mem_r_q <= exe_mem_r_d;
      mem_dest_q  <= exe_dest_q;
      mem_wb_en_q <= exe_wb_en_q;
      wb_dest_q   <= mem_dest_q;
      sel_src1_q  <= sel_src1_d;
      sel_src2_q  <= sel_src2_d;
    end
  end

  assign sel_src1   = sel_src1_q;
  assign sel_src2   = sel_src2_q;
  assign exe_dest_o = exe_dest_q;
  assign mem_dest_o = mem_dest_q;
  assign wb_dest_o  = wb_dest_q;

endmodule

// File: doc/forward_hazard_ctrl.md
Name: forward_hazard_ctrl

Overview:
- Sequential control block that sits directly upstream of the EXE-stage 3-to-1 operand multiplexers in the 5-stage ARM pipeline (IF/ID/EXE/MEM/WB).
- Tracks destination register, write-back enable and memory-read flag for the instructions in EXE, MEM and WB in an internal shadow pipeline.
- Produces registered 2-bit forwarding selects that line up with the instruction entering EXE.
- Raises a combinational hazard flag that freezes IF/ID and injects a bubble.

Parameters:
- REG_ADDR_W, 4, register-index width (R0..R15).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk only.
- forward_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- flush  in  1  branch taken in EXE; the instruction leaving ID is squashed.
- id_src1  in  REG_ADDR_W  first source register of the instruction in ID.
- id_src2  in  REG_ADDR_W  second source register of the instruction in ID.
- id_two_src  in  1  id_src2 is a real operand.
- id_dest  in  REG_ADDR_W  destination register of the instruction in ID.
- id_wb_en  in  1  the instruction in ID writes a register.
- id_mem_r_en  in  1  the instruction in ID is a load.
- hazard  out  1  combinational; 1 = freeze PC and IF/ID, insert a bubble into EXE.
- sel_src1  out  2  registered select for the EXE operand-1 mux.
- sel_src2  out  2  registered select for the EXE operand-2 mux.
- exe_dest_o, mem_dest_o, wb_dest_o  out  REG_ADDR_W each  shadow destinations, exported for debug and verification.

Behaviour:
- Select encoding matches the EXE muxes: 00 = ID/register-file value, 01 = WB value, 10 = MEM value; 11 is never driven.
- State: three stage slots (EXE, MEM, WB), each holding {dest, wb_en, mem_r_en}, plus sel_src1_q and sel_src2_q.
- Reset (rst == 0 at a rising edge): all slot fields = 0, sel_src1 = sel_src2 = 00. hazard depends only on slot contents, so it reads 0 the cycle after reset.
- Reset has priority over flush and hazard. Reset asserted mid-stream clears all in-flight tracking within one edge.
- Every edge: WB slot <= MEM slot, and MEM slot <= EXE slot. This always happens; stalls do not freeze EXE and later stages.
- EXE slot load:
  - If hazard or flush: bubble (all fields 0).
  - Otherwise: {id_dest, id_wb_en, id_mem_r_en}.
- Match function m(src, slot) = slot.wb_en && slot.dest == src.
- Operand 2 is considered only when id_two_src = 1; otherwise treat it as unused.
- Forwarding select, computed from the pre-edge EXE and MEM slots and registered on the edge:
  - If m(src, EXE): sel = 10. That producer sits in MEM when the consumer reaches EXE.
  - Else if m(src, MEM): sel = 01. That producer sits in WB.
  - Else: sel = 00.
  - The EXE match has priority; the youngest producer wins.
- Registered sel is forced to 00 when hazard, flush or forward_en = 0 in that cycle.
- hazard, forwarding mode (forward_en = 1): asserted iff the EXE slot has mem_r_en = 1 and m(used src, EXE). This is a load-use hazard, giving exactly one stall cycle.
- hazard, stall-only mode (forward_en = 0): asserted iff m(used src, EXE) or m(used src, MEM). This gives up to two stall cycles.
- Register-file write in WB is handled in the file itself, so the WB slot never causes a hazard.
- Unused operand: src2 is ignored when id_two_src = 0, even if its field matches.
- Simultaneous flush and hazard: the bubble is inserted and hazard stays asserted, since it is combinational.
- flush does not clear the MEM or WB slots.
- Latency: sel is valid in the same cycle the consumer occupies EXE, i.e. one edge after ID evaluation.
- forward_en may toggle at any time; it takes effect on the next edge for sel, and immediately for hazard.

Test Plan:
1. Reset mid-stream: slots loaded with dest = 3/5/7, wb_en = 1; drive rst = 0 for one edge -> all *_dest_o = 0, sel = 00, hazard = 0 the next cycle.
2. Forwarding from MEM: id_dest = 2, wb_en = 1; next instruction has src1 = 2, forward_en = 1 -> after the edge sel_src1 = 10, sel_src2 = 00, hazard never asserted.
3. Forwarding from WB: R4 producer, then an unrelated instruction, then a consumer with src2 = 4, two_src = 1 -> sel_src2 = 01. Repeat with two_src = 0 -> sel_src2 = 00.
4. Priority: producers of R6 in back-to-back instructions, then a consumer with src1 = 6 -> sel_src1 = 10, not 01.
5. Load-use: load with dest = 1, then a consumer with src1 = 1, forward_en = 1 -> hazard = 1 for exactly 1 cycle. The EXE slot bubble is visible as exe_dest_o = 0. The consumer then enters EXE with sel_src1 = 01.
6. Stall-only mode plus flush: forward_en = 0, producer of R9 then a consumer of R9 -> hazard high for 2 cycles with sel = 00 throughout. Separately, flush = 1 with id_wb_en = 1 -> EXE slot loads a bubble and MEM/WB keep shifting.
